// File: rtl/sram_arbiter_2to1.sv
// sram_arbiter_2to1: shares one 1-cycle-latency single-port SRAM between a fetch port and a data port.
// Data has priority; a saturating burst counter forces one fetch grant after DATA_MAX_BURST data grants.
module sram_arbiter_2to1 #(
  parameter int unsigned DATA_MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);
  localparam logic [3:0] MAX_BURST = 4'(DATA_MAX_BURST);
  logic       resp_vld_q, resp_vld_d;
  logic       resp_port_q, resp_port_d;
  logic       resp_rd_q, resp_rd_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       force_inst, grant_data, grant_inst, grant_wr;
  // resetn gates the grant so every request-driven output is 0 while in reset
  always_comb begin
    force_inst = (MAX_BURST != 4'd0) && (burst_cnt_q == MAX_BURST);
    grant_data = resetn && data_req && !(inst_req && force_inst);
    grant_inst = resetn && inst_req && !grant_data;
    grant_wr   = grant_data && data_wr;
  end
  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign sram_en      = grant_data || grant_inst;
  assign sram_we      = grant_wr ? data_wstrb : 4'h0;
  assign sram_addr    = grant_data ? data_addr : grant_inst ? inst_addr : 32'h0;
  assign sram_wdata   = grant_wr ? data_wdata : 32'h0;
  assign inst_data_ok = resp_vld_q && !resp_port_q;
  assign data_data_ok = resp_vld_q && resp_port_q;
  assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
  assign data_rdata   = (data_data_ok && resp_rd_q) ? sram_rdata : 32'h0;
  always_comb begin
    resp_vld_d  = grant_data || grant_inst;
    resp_port_d = grant_data;
    resp_rd_d   = grant_inst || (grant_data && !data_wr);
    burst_cnt_d = (grant_data && inst_req) ? ((burst_cnt_q == 4'hf) ? 4'hf : burst_cnt_q + 4'd1)
                : (grant_inst || !inst_req) ? 4'h0 : burst_cnt_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_vld_q  <= 1'b0;
      resp_port_q <= 1'b0;
      resp_rd_q   <= 1'b0;
      burst_cnt_q <= 4'h0;
    end else begin
      resp_vld_q  <= resp_vld_d;
      resp_port_q <= resp_port_d;
      resp_rd_q   <= resp_rd_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
endmodule
